inport_fifo_rc: RTL
===================

// Module: inport_fifo_rc
// PURPOSE
//  Router input port: receiving end of the flit link driven by a neighbour's switch allocator output.
//  - Buffers incoming flits in a DEPTH-entry FIFO and back-pressures upstream with full.
//  - Computes the XY route label of the head flit.
//  - Presents data and label to the local switch allocator; pops the head on ready.
// PARAMETERS
//  DEPTH     8   FIFO entries; must equal 2**WIDTH
//  WIDTH     3   read/write pointer width
//  DATASIZE  40  flit: src[39:36] dst[35:32] timestamp[31:24] data[23:2] type[1:0]
//  CUR_X     0   this router's X coordinate (2 bit)
//  CUR_Y     0   this router's Y coordinate (2 bit)
// PORTS
//  clk            in   1         clock
//  rst_n          in   1         asynchronous active-low reset
//  data_valid_in  in   1         upstream flit valid
//  data_in        in   DATASIZE  upstream flit
//  full           out  1         FIFO full; upstream must not send
//  ready          in   1         switch allocator pops head this cycle
//  label          out  4         head route: 0 none,1 L,2 N,3 E,4 S,5 W
//  data_out       out  DATASIZE  head flit (first-word fall-through)
//  empty          out  1         FIFO empty
//  overflow_err   out  1         sticky: flit arrived while full
// BEHAVIOUR
//  - Reset (async, rst_n=0): rd_ptr=wr_ptr=0, count=0, overflow_err=0.
//    Outputs then: empty=1, full=0, label=0, data_out=mem[0]; memory not cleared.
//  - Storage: count is WIDTH+1 bits; full=(count==DEPTH), empty=(count==0), both combinational from count.
//  - push = data_valid_in & ~full; pop = ready & ~empty; evaluated on rising clk.
//  - Push: mem[wr_ptr]<=data_in; wr_ptr+1 wraps DEPTH-1->0 naturally (WIDTH bits).
//  - Pop: rd_ptr+1, same wrap rule.
//  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - Full + data_valid_in: flit dropped, overflow_err<=1 until reset, even if pop same cycle.
//    No push-through when full.
//  - Empty + ready: ignored, no pointer change. No bypass: a flit pushed into an empty FIFO
//    at edge N is visible at data_out/label from edge N (1-cycle latency), poppable at edge N+1.
//  - data_out=mem[rd_ptr] combinational; undefined content when empty; consumers qualify with label!=0.
//  - Label: combinational XY route from head dst; x=dst[35:34], y=dst[33:32]; 0 when empty. Priority order:
//    x>CUR_X -> E(3); x<CUR_X -> W(5); else y<CUR_Y -> N(2); y>CUR_Y -> S(4); else L(1).
//  - Reset mid-operation: all buffered flits discarded, state as after reset; label=0 same cycle rst_n falls.
//  - Back-to-back push every cycle with pop every cycle sustains full throughput, count constant.
// CONFIGURATION
//  INPORT_HOP_COUNT_EN
//   defined: data_out timestamp field [31:24] = head timestamp+1, saturating at 8'hFF; other fields unchanged.
//            Stored flit not modified; label unaffected.
//   undefined: data_out = stored head flit bit-exact.
// TESTING
//  1 Reset: rst_n=0 -> empty=1, full=0, label=0, overflow_err=0.
//  2 CUR_X=1,CUR_Y=1; push dst=4'b1001 (x2,y1) -> next cycle label=3 (E).
//    Push 4'b0101 behind it; pop -> label=1 (L).
//  3 Fill: 8 pushes, no ready -> full=1 after 8th edge.
//    9th valid flit dropped, overflow_err=1; drain 8 pops returns flits in order, empty=1.
//  4 Full + simultaneous valid and ready -> pop occurs, push dropped, count=7, overflow_err=1.
//  5 Wrap: 12 push/pop pairs at 1 per cycle -> data order preserved across ptr wrap, count stays 1.
//  6 INPORT_HOP_COUNT_EN: push timestamp 8'h10 -> data_out[31:24]=8'h11.
//    Push timestamp 8'hFF -> data_out[31:24]=8'hFF.

Source files
------------

// File: rtl/inport_fifo_rc_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : inport_fifo_rc_if                                        |
// | Brief   : Flit link between upstream sender, input FIFO and the    |
// |           local switch allocator.                                  |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
interface inport_fifo_rc_if #(
    parameter int DATASIZE = 40
) ();
    logic                data_valid_in;
    logic [DATASIZE-1:0] data_in;
    logic                full;
    logic                ready;
    logic [3:0]          label;
    logic [DATASIZE-1:0] data_out;
    logic                empty;
    logic                overflow_err;

    // FIFO side
    modport slave (
        input  data_valid_in, data_in, ready,
        output full, label, data_out, empty, overflow_err
    );

    // Upstream sender plus allocator side
    modport master (
        output data_valid_in, data_in, ready,
        input  full, label, data_out, empty, overflow_err
    );
endinterface
`default_nettype wire

// File: rtl/inport_fifo_rc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : inport_fifo_rc                                           |
// | Brief   : Router input port: DEPTH-entry flit FIFO with XY route   |
// |           computation on the head flit. Optional macro             |
// |           INPORT_HOP_COUNT_EN bumps the presented timestamp.       |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module inport_fifo_rc #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40,
    parameter int CUR_X    = 0,
    parameter int CUR_Y    = 0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    inport_fifo_rc_if.slave   bus
);

    localparam logic [WIDTH:0] C_DEPTH = (WIDTH+1)'(DEPTH);
    localparam logic [1:0]     C_CUR_X = 2'(CUR_X);
    localparam logic [1:0]     C_CUR_Y = 2'(CUR_Y);

    localparam logic [3:0] C_LBL_NONE = 4'd0;
    localparam logic [3:0] C_LBL_L    = 4'd1;
    localparam logic [3:0] C_LBL_N    = 4'd2;
    localparam logic [3:0] C_LBL_E    = 4'd3;
    localparam logic [3:0] C_LBL_S    = 4'd4;
    localparam logic [3:0] C_LBL_W    = 4'd5;

    logic [DATASIZE-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [WIDTH:0]      count_q,  count_d;
    logic                overflow_q, overflow_d;

    logic                full, empty, push, pop;
    logic [DATASIZE-1:0] head;
    logic [1:0]          dst_x, dst_y;

    assign full  = (count_q == C_DEPTH);
    assign empty = (count_q == '0);
    // A flit offered while full is dropped even if a pop frees a slot this cycle
    assign push  = bus.data_valid_in & ~full;
    assign pop   = bus.ready & ~empty;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (bus.data_valid_in & full);
        if (push) wr_ptr_d = wr_ptr_q + WIDTH'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + WIDTH'(1);
        if (push && !pop)      count_d = count_q + (WIDTH+1)'(1);
        else if (pop && !push) count_d = count_q - (WIDTH+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; emptiness is tracked by count alone
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.data_in;
    end

    assign head  = mem_q[rd_ptr_q];
    assign dst_x = head[35:34];
    assign dst_y = head[33:32];

    always_comb begin
        bus.label = C_LBL_NONE;
        if (!empty) begin
            if (dst_x > C_CUR_X)      bus.label = C_LBL_E;
            else if (dst_x < C_CUR_X) bus.label = C_LBL_W;
            else if (dst_y < C_CUR_Y) bus.label = C_LBL_N;
            else if (dst_y > C_CUR_Y) bus.label = C_LBL_S;
            else                      bus.label = C_LBL_L;
        end
    end

`ifdef INPORT_HOP_COUNT_EN
    logic [7:0] ts_inc;
    assign ts_inc       = (head[31:24] == 8'hFF) ? 8'hFF : head[31:24] + 8'd1;
    assign bus.data_out = {head[DATASIZE-1:32], ts_inc, head[23:0]};
`else
    assign bus.data_out = head;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.overflow_err = overflow_q;

endmodule
`default_nettype wire
